// File: rtl/edge_sched_pkg.sv
// nandy_pkg: shared types for the edge_sched gated-clock scheduler.
// No ports; provides the FSM state type and an index-width helper.
package nandy_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } state_e;

    // Width of an index into n items; never below 1 bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/edge_sched_if.sv
// edge_sched_if: request/control inputs and enable/debug outputs.
// master drives req/lock/halt/step/step_count; slave drives en/grant_id/stepping/edges.
interface edge_sched_if
    import nandy_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int STEP_W = 8
);
    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic              halt;
    logic              step;
    logic [STEP_W-1:0] step_count;
    logic [NREQ-1:0]   en;
    logic [IW-1:0]     grant_id;
    logic              stepping;
    logic [15:0]       edges;

    modport master (
        output req, lock, halt, step, step_count,
        input  en, grant_id, stepping, edges
    );

    modport slave (
        input  req, lock, halt, step, step_count,
        output en, grant_id, stepping, edges
    );

endinterface

// File: rtl/edge_sched_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts after 'last'.
// Ports: req/mask in, last in (index); gnt one-hot out, idx out (last if none).
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic [NREQ-1:0] eff;
    logic            hit;

    assign eff = req & mask;

    always_comb begin
        gnt = '0;
        idx = last;
        hit = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!hit && eff[(int'(last) + i) % NREQ]) begin
                hit = 1'b1;
                idx = IW'((int'(last) + i) % NREQ);
                gnt[(int'(last) + i) % NREQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_sched.sv
// edge_sched: picks which edgegate gets the next rising edge (RR, lock, halt/step).
// Ports: clk, nrst (sync, active low), bus (edge_sched_if.slave).
module edge_sched
    import nandy_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int STEP_W   = 8,
    parameter int LOCK_MAX = 4
) (
    input logic        clk,
    input logic        nrst,
    edge_sched_if.slave bus
);

    localparam int IW = idx_w(NREQ);
    localparam int LW = idx_w(LOCK_MAX + 1);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   en_q, en_d;
    logic [IW-1:0]     gid_q, gid_d;
    logic [LW-1:0]     lk_q, lk_d;
    logic [STEP_W-1:0] sc_q, sc_d;
    logic [15:0]       ed_q, ed_d;
    logic              stp_q, stp_d;

    logic              allow;
    logic              step_mode;
    logic [STEP_W-1:0] budget;
    logic              hold;
    logic [NREQ-1:0]   pick_oh;
    logic [IW-1:0]     pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (bus.req),
        .last (gid_q),
        .mask ({NREQ{allow}}),
        .gnt  (pick_oh),
        .idx  (pick_idx)
    );

    // Lock only extends an edge the owner is actually holding right now.
    assign hold = (|en_q) && bus.req[gid_q] && bus.lock[gid_q]
                  && (int'(lk_q) < LOCK_MAX);

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        step_mode = 1'b0;
        budget    = sc_q;
        allow     = 1'b0;

        unique case (state_q)
            RUN: begin
                if (bus.halt) state_d = HALTED;
                else          allow   = 1'b1;
            end
            HALTED: begin
                // Halt release wins over a coincident step.
                if (!bus.halt) begin
                    state_d = RUN;
                    allow   = 1'b1;
                end else if (bus.step) begin
                    step_mode = 1'b1;
                    budget    = (bus.step_count == '0) ?
                                STEP_W'(1) : bus.step_count;
                end
            end
            STEP: begin
                if (!bus.halt) begin
                    state_d = RUN;
                    allow   = 1'b1;
                    sc_d    = '0;
                end else begin
                    step_mode = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (step_mode) allow = (budget != '0);

        en_d  = '0;
        gid_d = gid_q;
        lk_d  = lk_q;
        if (allow && hold) begin
            en_d = en_q;
            lk_d = lk_q + LW'(1);
        end else if (allow && (|pick_oh)) begin
            en_d  = pick_oh;
            gid_d = pick_idx;
            lk_d  = LW'(1);
        end

        // Steps are only consumed by edges actually granted.
        if (step_mode) begin
            sc_d    = budget;
            state_d = STEP;
            if (|en_d) begin
                sc_d = budget - STEP_W'(1);
                if (budget == STEP_W'(1)) state_d = HALTED;
            end
        end

        stp_d = step_mode;
        ed_d  = ed_q + 16'(|en_d);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= RUN;
            en_q    <= '0;
            gid_q   <= IW'(NREQ - 1);
            lk_q    <= '0;
            sc_q    <= '0;
            ed_q    <= '0;
            stp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            gid_q   <= gid_d;
            lk_q    <= lk_d;
            sc_q    <= sc_d;
            ed_q    <= ed_d;
            stp_q   <= stp_d;
        end
    end

    assign bus.en       = en_q;
    assign bus.grant_id = gid_q;
    assign bus.stepping = stp_q;
    assign bus.edges    = ed_q;

endmodule

// File: doc/edge_sched.md
# edge_sched

Scheduler for a bank of `edgegate` positive-edge gates that share one clock.
- Each cycle it decides which single gated clock domain (register, latch bank or stage) receives the next rising edge.
- It drives the `en` input of each `edgegate` from a registered one-hot vector.
- It provides round-robin fairness, bounded lock (burst) ownership, and a halt/single-step control for debug and bring-up.

## Interface
Parameters:
- `NREQ`, 4, number of requesters, one per edgegate; range 2..8.
- `STEP_W`, 8, width of the step-count field.
- `LOCK_MAX`, 4, maximum consecutive edges one requester may hold via `lock`; must be at least 1.

Ports:
- `clk`, in, 1: the single ungated clock, also fed to every edgegate.
- `nrst`, in, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req`, in, NREQ: requester i wants the next edge.
- `lock`, in, NREQ: the current owner wants to keep the grant for its next edge.
- `halt`, in, 1: level; while high, no new edges are granted except through stepping.
- `step`, in, 1: pulse; while halted, launch a burst of `step_count` scheduled edges.
- `step_count`, in, STEP_W: edges per step burst; 0 is treated as 1.
- `en`, out, NREQ: one-hot or zero, registered; connects to the edgegate `en` inputs.
- `grant_id`, out, clog2(NREQ): index of the current owner, valid when `en` is nonzero.
- `stepping`, out, 1: a step burst is in progress.
- `edges`, out, 16: wrapping count of granted edges, for debug.

## Operation
- FSM states:
  - RUN: grant normally.
  - HALTED: `en` = 0.
  - STEP: grant normally while the step counter is nonzero.
- FSM transitions:
  - RUN goes to HALTED when `halt`=1.
  - HALTED goes to RUN when `halt`=0.
  - HALTED goes to STEP when `step`=1.
  - STEP goes to HALTED when the counter reaches 0 after a granted edge.
  - STEP goes to RUN if `halt` drops; this takes priority and the remaining count is discarded.
- Arbitration:
  - Round-robin starting at the index after `grant_id`.
  - The next `en` is one-hot at the first asserted `req`, or zero if `req`=0.
- Lock:
  - If the owner has `req[g]`=1 and `lock[g]`=1 and its lock count is less than `LOCK_MAX`, it keeps the grant.
  - Otherwise it rotates.
  - The lock count resets to 1 on every change of owner.
- An owner that drops `req` loses the grant in the next cycle even if `lock` is high.
- Counters:
  - The step counter decrements only on cycles where `en` is nonzero; an idle `req` does not consume steps.
  - `edges` increments when `en` is nonzero and wraps from 0xFFFF to 0.
- `step` is ignored in RUN and in STEP; a new step is accepted only in HALTED.
- A `step` that arrives in the same cycle as `halt` falling enters RUN.

## Timing
- `en` is updated on the rising edge of `clk`. It is therefore stable for the whole following low phase, while the edgegate latch is transparent.
- The edge it enables is the next rising edge.
- Latency: `req` asserted at edge k produces `en` at edge k+1 and the gated edge at k+2.
- `halt` asserted at edge k gives `en`=0 after k+1. The edge at k+1 is still delivered if `en` was already set.
- Reset (`nrst`=0 at an edge):
  - State is RUN; `en`=0, `grant_id`=NREQ-1 (so index 0 wins first), `stepping`=0, `edges`=0, lock count=0, step counter=0.
  - Reset applied mid-burst or mid-lock takes effect on the same edge and overrides everything.
- `en` is never multi-hot, including across owner changes; a change of owner happens in one registered update.

## Structure
- Shared package `nandy_pkg`: the FSM state enum (RUN, HALTED, STEP) and a `clog2`-based index-width constant helper.
- One sub-module, `rr_pick`: a combinational round-robin priority picker with inputs `req`, `last` and `mask`, and outputs the one-hot result and its index. The top level holds the FSM, lock counter, step counter and edge counter.

## Test plan
- Reset: hold `nrst`=0 for 3 edges with `req`=4'b1111 -> `en`=0 throughout; first `en` after release is 4'b0001, then 0010, 0100, 1000, 0001.
- Lock bound, `LOCK_MAX`=4: `req`=4'b0011, `lock`=4'b0001 -> `en`=0001 for 4 edges, then 0010 for 1 edge, then 0001 again. Dropping `req[0]` mid-lock moves `en` to 0010 on the next edge.
- Halt: `halt`=1 while `en`=0100 -> exactly one more edge is delivered, then `en`=0; `edges` is frozen; `halt`=0 resumes at index 3.
- Step: in HALTED, `step` with `step_count`=3 and `req`=4'b1010 -> `en` = 0010, 1000, 0010, then 0; `stepping` is high for 3 cycles. `step_count`=0 gives exactly 1 edge.
- Step with gaps: `step_count`=2 and `req` low for 5 cycles mid-burst -> the counter holds during the gap; 2 edges are still delivered in total.
- Wrap and one-hot: preload `edges` near 0xFFFE with random `req`/`lock`/`halt` for 10k cycles -> `edges` wraps to 0; an assertion that `en` is never multi-hot holds throughout.
